unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between the CPU fetch port (I) and the load/store port (D).
- Allows one outstanding read at a time. Ties between I and D are resolved round-robin.
- Variable-latency read responses are routed back to the port that issued the read.
- A timeout counter converts lost responses into error completions so the CPU pipeline cannot hang.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.
- TIMEOUT, 16, maximum number of cycles spent waiting for mem_rvalid before an error completion; must be ≥2.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid (1-cycle pulse).
- if_rdata  out  DATA_WIDTH  fetch response data.
- if_err  out  1  fetch response is a timeout error (qualifies if_rvalid).
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  write data.
- d_be  in  DATA_WIDTH/8  byte enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  data read response valid (1-cycle pulse).
- d_rdata  out  DATA_WIDTH  data read response.
- d_err  out  1  data response is a timeout error.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_be  out  DATA_WIDTH/8  memory byte enables.
- mem_rvalid  in  1  memory read data valid.
- mem_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - state = IDLE, owner = I, last_grant = D, timeout counter = 0.
  - All gnt, rvalid, err and mem_req outputs are 0 during and after reset.
  - rdata outputs are 0 whenever the corresponding rvalid is 0.
- States: IDLE and WAIT.
- Arbitration in IDLE (combinational, same cycle):
  - Only one requester active → it wins.
  - Both active → the port that is not last_grant wins.
  - Winner gets gnt = 1; the loser gets gnt = 0 and must hold its request stable.
- Memory drive:
  - In the grant cycle, mem_req = 1 and mem_we/addr/wdata/be pass through combinationally from the winner.
  - For I, mem_we = 0 and mem_be = all ones.
  - In all other cycles mem_req = 0 and the other mem_* outputs are 0.
- On grant (rising edge): last_grant <= winner.
- Write grant (D with d_we = 1):
  - Completes in the grant cycle with no response.
  - State stays IDLE, so a new grant is possible in the very next cycle.
- Read grant:
  - owner <= winner, counter <= 0, state <= WAIT.
  - No grants are issued while in WAIT.
- In WAIT:
  - If mem_rvalid = 1 in a cycle: owner's rvalid = 1 and rdata = mem_rdata (combinational pass-through), err = 0. State <= IDLE.
  - Else, if counter == TIMEOUT-1: owner's rvalid = 1, err = 1, rdata = 0. State <= IDLE.
  - Else: counter increments.
- Timing:
  - Read latency as seen by a port = memory latency; the earliest response is 1 cycle after the grant.
  - Back-to-back reads: next grant is possible in the cycle after the response.
- Boundary conditions:
  - mem_rvalid in IDLE (stray or late response after timeout): ignored, no port output.
  - mem_rvalid in the grant cycle itself: ignored.
  - rst asserted in WAIT: outstanding read dropped, no response issued; a later mem_rvalid is ignored.
  - rst has priority over every other event in the same cycle.
  - A requester dropping req before its grant is legal; it is simply not granted.
  - The non-owner port never sees rvalid.

Test Plan:
1. I read at 0x0 with memory latency 1, mem_rdata = 0x00A00193.
   → if_gnt in cycle 0; mem_addr = 0x0, mem_we = 0, mem_be = 0xF; if_rvalid = 1 with if_rdata = 0x00A00193 in cycle 1; d_rvalid stays 0.
2. Both ports request right after reset: I read 0x4, D read 0x100, memory latency 2, data 0x11 then 0x22.
   → I granted first, if_rdata = 0x11 two cycles later.
   → D granted in the next IDLE cycle, d_rdata = 0x22.
   → last_grant alternates I, D, I across three tie rounds.
3. D write to addr 0x200, wdata 0xDEADBEEF, be 0x3, followed immediately by an I read.
   → mem_we = 1 with mem_be = 0x3 in cycle 0, no d_rvalid.
   → if_gnt in cycle 1.
4. D read with memory never responding, TIMEOUT = 16.
   → d_rvalid = 1, d_err = 1, d_rdata = 0 exactly 16 cycles after the grant.
   → a mem_rvalid arriving 3 cycles later produces no output.
5. Reset mid-read: I granted, rst asserted 1 cycle later, then mem_rvalid pulses after rst is released.
   → no if_rvalid; all outputs 0 during reset; the next tie grants I.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch (I) and load/store (D) ports.
// One read may be outstanding; a timeout turns a lost response into an error completion.
module unified_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_gnt,
  output logic                    if_rvalid,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  output logic                    if_err,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_be,
  output logic                    d_gnt,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_err,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);
  localparam int BEW = DATA_WIDTH / 8;
  localparam int CW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] WAIT   = 1'b1;
  localparam logic       PORT_I = 1'b0;
  localparam logic       PORT_D = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          pick_d, rsp, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    rsp       = 1'b0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    // On a tie D wins only when I was granted last.
    pick_d    = d_req & (~if_req | (last_q == PORT_I));
    if (!rst && state_q == IDLE && (if_req || d_req)) begin
      mem_req = 1'b1;
      last_d  = pick_d;
      if (pick_d) begin
        d_gnt     = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
        if (!d_we) begin
          state_d = WAIT;
          owner_d = PORT_D;
          cnt_d   = '0;
        end
      end else begin
        if_gnt   = 1'b1;
        mem_addr = if_addr;
        mem_be   = {BEW{1'b1}};
        state_d  = WAIT;
        owner_d  = PORT_I;
        cnt_d    = '0;
      end
    end else if (!rst && state_q == WAIT) begin
      if (mem_rvalid || cnt_q == CW'(TIMEOUT - 1)) begin
        rsp      = 1'b1;
        rsp_err  = ~mem_rvalid;
        rsp_data = mem_rvalid ? mem_rdata : '0;
        state_d  = IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign if_rvalid = rsp & (owner_q == PORT_I);
  assign if_err    = if_rvalid & rsp_err;
  assign if_rdata  = if_rvalid ? rsp_data : '0;
  assign d_rvalid  = rsp & (owner_q == PORT_D);
  assign d_err     = d_rvalid & rsp_err;
  assign d_rdata   = d_rvalid ? rsp_data : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      last_q  <= PORT_D;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: transaction-level model checked every cycle
// plus literal expectations taken from the hand-worked scenarios.
module tb_unified_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic [3:0]    d_be = '0;
  logic          d_gnt, d_rvalid, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_be;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  unified_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an outstanding read is just (owner, grant cycle); it completes on the
  // first mem_rvalid after the grant, or as an error TO cycles after the grant.
  int cyc = 0;
  bit m_busy = 0, m_owner = 0, m_last = 1;
  int m_gcyc = 0;

  always @(negedge clk) begin
    bit e_ig, e_dg, e_mreq, e_mwe, e_iv, e_dv, e_ie, e_de, win, rsp, err;
    logic [AW-1:0] e_maddr;
    logic [DW-1:0] e_mwd, e_id, e_dd, rdat;
    logic [3:0] e_mbe;
    e_ig = 0; e_dg = 0; e_mreq = 0; e_mwe = 0; e_iv = 0; e_dv = 0; e_ie = 0; e_de = 0;
    e_maddr = '0; e_mwd = '0; e_id = '0; e_dd = '0; e_mbe = '0;
    win = 0; rsp = 0; err = 0; rdat = '0;
    if (!rst) begin
      if (!m_busy && (if_req || d_req)) begin
        win = (if_req && d_req) ? !m_last : d_req;
        e_mreq = 1;
        if (win) begin
          e_dg = 1; e_mwe = d_we; e_maddr = d_addr; e_mwd = d_wdata; e_mbe = d_be;
        end else begin
          e_ig = 1; e_maddr = if_addr; e_mbe = 4'hF;
        end
      end else if (m_busy) begin
        if (mem_rvalid) begin rsp = 1; rdat = mem_rdata; end
        else if (cyc - m_gcyc == TO) begin rsp = 1; err = 1; end
      end
      if (rsp) begin
        if (m_owner) begin e_dv = 1; e_de = err; e_dd = rdat; end
        else begin e_iv = 1; e_ie = err; e_id = rdat; end
      end
    end
    chk("m.if_gnt", 64'(if_gnt), 64'(e_ig));
    chk("m.d_gnt", 64'(d_gnt), 64'(e_dg));
    chk("m.mem_req", 64'(mem_req), 64'(e_mreq));
    chk("m.mem_we", 64'(mem_we), 64'(e_mwe));
    chk("m.mem_addr", 64'(mem_addr), 64'(e_maddr));
    chk("m.mem_wdata", 64'(mem_wdata), 64'(e_mwd));
    chk("m.mem_be", 64'(mem_be), 64'(e_mbe));
    chk("m.if_rvalid", 64'(if_rvalid), 64'(e_iv));
    chk("m.if_err", 64'(if_err), 64'(e_ie));
    chk("m.if_rdata", 64'(if_rdata), 64'(e_id));
    chk("m.d_rvalid", 64'(d_rvalid), 64'(e_dv));
    chk("m.d_err", 64'(d_err), 64'(e_de));
    chk("m.d_rdata", 64'(d_rdata), 64'(e_dd));
    if (rst) begin
      m_busy = 0; m_last = 1;
    end else begin
      if (e_mreq) begin
        m_last = win;
        if (!(win && d_we)) begin m_busy = 1; m_owner = win; m_gcyc = cyc; end
      end
      if (rsp) m_busy = 0;
    end
    cyc++;
  end

  // Advance to just after the next rising edge and clear all stimulus.
  task automatic nxt();
    @(posedge clk);
    #1;
    rst = 0; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  initial begin
    // Reset
    @(posedge clk); #1;
    if_req = 1; d_req = 1;
    #2;
    chk("rst.if_gnt", 64'(if_gnt), 64'd0);
    chk("rst.mem_req", 64'(mem_req), 64'd0);
    nxt();

    // 1: I read, latency 1
    if_req = 1; if_addr = 32'h0; #2;
    chk("t1.if_gnt", 64'(if_gnt), 64'd1);
    chk("t1.mem_be", 64'(mem_be), 64'hF);
    chk("t1.mem_we", 64'(mem_we), 64'd0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h00A00193; #2;
    chk("t1.if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1.if_rdata", 64'(if_rdata), 64'h00A00193);
    chk("t1.d_rvalid", 64'(d_rvalid), 64'd0);

    // 2: ties after reset, alternating I, D, I
    nxt(); rst = 1;
    nxt(); rst = 1;
    nxt(); if_req = 1; if_addr = 32'h4; d_req = 1; d_addr = 32'h100; #2;
    chk("t2.r1.if_gnt", 64'(if_gnt), 64'd1);
    chk("t2.r1.d_gnt", 64'(d_gnt), 64'd0);
    nxt(); d_req = 1; d_addr = 32'h100; #2;
    chk("t2.wait.d_gnt", 64'(d_gnt), 64'd0);
    nxt(); d_req = 1; d_addr = 32'h100; mem_rvalid = 1; mem_rdata = 32'h11; #2;
    chk("t2.if_rdata", 64'(if_rdata), 64'h11);
    chk("t2.rsp.d_gnt", 64'(d_gnt), 64'd0);
    nxt(); d_req = 1; d_addr = 32'h100; if_req = 1; if_addr = 32'h8; #2;
    chk("t2.r2.d_gnt", 64'(d_gnt), 64'd1);
    chk("t2.r2.if_gnt", 64'(if_gnt), 64'd0);
    chk("t2.r2.mem_addr", 64'(mem_addr), 64'h100);
    nxt(); if_req = 1; if_addr = 32'h8;
    nxt(); if_req = 1; if_addr = 32'h8; mem_rvalid = 1; mem_rdata = 32'h22; #2;
    chk("t2.d_rvalid", 64'(d_rvalid), 64'd1);
    chk("t2.d_rdata", 64'(d_rdata), 64'h22);
    chk("t2.if_rvalid", 64'(if_rvalid), 64'd0);
    nxt(); if_req = 1; if_addr = 32'h8; d_req = 1; d_addr = 32'h104; #2;
    chk("t2.r3.if_gnt", 64'(if_gnt), 64'd1);
    nxt(); d_req = 1; d_addr = 32'h104; mem_rvalid = 1; mem_rdata = 32'h33; #2;
    chk("t2.r3.if_rdata", 64'(if_rdata), 64'h33);
    nxt(); d_req = 1; d_addr = 32'h104; #2;
    chk("t2.d2.d_gnt", 64'(d_gnt), 64'd1);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h44; #2;
    chk("t2.d2.d_rdata", 64'(d_rdata), 64'h44);

    // 3: D write then immediate I read
    nxt(); d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_be = 4'h3; #2;
    chk("t3.d_gnt", 64'(d_gnt), 64'd1);
    chk("t3.mem_we", 64'(mem_we), 64'd1);
    chk("t3.mem_be", 64'(mem_be), 64'h3);
    chk("t3.mem_wdata", 64'(mem_wdata), 64'hDEADBEEF);
    nxt(); if_req = 1; if_addr = 32'h10; #2;
    chk("t3.if_gnt", 64'(if_gnt), 64'd1);
    chk("t3.d_rvalid", 64'(d_rvalid), 64'd0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h55; #2;
    chk("t3.if_rdata", 64'(if_rdata), 64'h55);

    // 4: D read never answered; grant-cycle mem_rvalid is ignored too
    nxt(); d_req = 1; d_addr = 32'h300; mem_rvalid = 1; mem_rdata = 32'h77; #2;
    chk("t4.d_gnt", 64'(d_gnt), 64'd1);
    chk("t4.gcyc.d_rvalid", 64'(d_rvalid), 64'd0);
    for (int k = 1; k <= TO; k++) begin
      nxt(); #2;
      if (k < TO) chk("t4.early.d_rvalid", 64'(d_rvalid), 64'd0);
      else begin
        chk("t4.to.d_rvalid", 64'(d_rvalid), 64'd1);
        chk("t4.to.d_err", 64'(d_err), 64'd1);
        chk("t4.to.d_rdata", 64'(d_rdata), 64'd0);
      end
    end
    nxt(); nxt();
    nxt(); mem_rvalid = 1; mem_rdata = 32'h99; #2;
    chk("t4.late.d_rvalid", 64'(d_rvalid), 64'd0);
    chk("t4.late.if_rvalid", 64'(if_rvalid), 64'd0);

    // 5: reset during an outstanding I read
    nxt(); if_req = 1; if_addr = 32'h20; #2;
    chk("t5.if_gnt", 64'(if_gnt), 64'd1);
    nxt(); rst = 1; mem_rvalid = 1; mem_rdata = 32'h66; if_req = 1; d_req = 1; #2;
    chk("t5.rst.if_rvalid", 64'(if_rvalid), 64'd0);
    chk("t5.rst.if_gnt", 64'(if_gnt), 64'd0);
    chk("t5.rst.d_gnt", 64'(d_gnt), 64'd0);
    nxt(); mem_rvalid = 1; mem_rdata = 32'h67; #2;
    chk("t5.post.if_rvalid", 64'(if_rvalid), 64'd0);
    chk("t5.post.if_gnt", 64'(if_gnt), 64'd0);
    nxt(); if_req = 1; if_addr = 32'h24; d_req = 1; d_addr = 32'h400; #2;
    chk("t5.tie.if_gnt", 64'(if_gnt), 64'd1);
    nxt(); d_req = 1; d_addr = 32'h400; mem_rvalid = 1; mem_rdata = 32'h88; #2;
    chk("t5.tie.if_rdata", 64'(if_rdata), 64'h88);
    nxt(); nxt();
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
